// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch : instruction fetch stage.
//
// Keeps the fetch PC, asks the instruction SRAM for the next fetch address,
// and hands the registered {ce, pc} pair to decode. A redirect that arrives
// while the stage is frozen is held in a one-entry pending slot and applied
// on the first free edge. A newer redirect replaces the held one while the
// stage is still frozen. A redirect that arrives on the free edge that
// drains the slot is dropped.
//
// Optional feature macro: IF_ALIGN_CHECK_EN
//   defined   : a misaligned next_pc on an updating edge sets a sticky
//               fetch_err flag, which also masks inst_sram_en until reset.
//   undefined : fetch_err is tied low and misaligned addresses pass through.
// ---------------------------------------------------------------------------

`ifndef StallBus
`define StallBus 6
`endif
`ifndef BR_WD
`define BR_WD 33
`endif
`ifndef IF_TO_ID_WD
`define IF_TO_ID_WD 33
`endif
`ifndef Stop
`define Stop 1'b1
`endif
`ifndef NoStop
`define NoStop 1'b0
`endif

module if_fetch (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [`StallBus-1:0]    stall,
  input  logic [`BR_WD-1:0]       br_bus,
  output logic [`IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic                    inst_sram_en,
  output logic [3:0]              inst_sram_wen,
  output logic [31:0]             inst_sram_addr,
  output logic [31:0]             inst_sram_wdata,
  output logic                    fetch_err
);

  // Reset PC sits one word below the boot vector, so the first computed
  // next_pc (pc + 4) is the boot address 0xBFC0_0000.
  localparam logic [31:0] RESET_PC = 32'hBFBF_FFFC;
  localparam logic [31:0] PC_STEP  = 32'h0000_0004;

  // Word-alignment test on a fetch address.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  logic        br_e;
  logic [31:0] br_addr;
  logic        advance;
  logic [31:0] next_pc;

  logic [31:0] pc_r;
  logic        ce_r;
  logic        pend_v;
  logic [31:0] pend_addr;
  logic        err_r;

  // Only bit 0 of the stall vector belongs to this stage.
  logic unused_stall;
  assign unused_stall = ^stall[`StallBus-1:1];

  assign br_e    = br_bus[`BR_WD-1];
  assign br_addr = br_bus[31:0];
  assign advance = (stall[0] == `NoStop);

  // Next fetch address: a held redirect beats a fresh one, which beats pc + 4.
  always_comb begin
    next_pc = pc_r + PC_STEP;
    if (pend_v) begin
      next_pc = pend_addr;
    end else if (br_e) begin
      next_pc = br_addr;
    end else begin
      next_pc = pc_r + PC_STEP;
    end
  end

  // Fetch state: advance on free edges; hold and capture redirects while frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r      <= RESET_PC;
      ce_r      <= 1'b0;
      pend_v    <= 1'b0;
      pend_addr <= 32'h0000_0000;
    end else if (advance) begin
      pc_r      <= next_pc;
      ce_r      <= 1'b1;
      pend_v    <= 1'b0;
      pend_addr <= pend_addr;
    end else if (br_e) begin
      pc_r      <= pc_r;
      ce_r      <= ce_r;
      pend_v    <= 1'b1;
      pend_addr <= br_addr;
    end else begin
      pc_r      <= pc_r;
      ce_r      <= ce_r;
      pend_v    <= pend_v;
      pend_addr <= pend_addr;
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  // Sticky misalignment flag, set when a misaligned address is loaded into pc.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else if (advance && is_misaligned(next_pc)) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end
`else
  logic unused_align;
  assign unused_align = is_misaligned(next_pc);
  assign err_r        = 1'b0;
`endif

  assign if_to_id_bus    = {ce_r, pc_r};
  assign inst_sram_en    = ce_r & ~err_r;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = next_pc;
  assign inst_sram_wdata = 32'h0000_0000;
  assign fetch_err       = err_r;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch : scoreboard bench for if_fetch.
// Stimulus applies one directed vector per cycle just after the rising edge
// and queues the hand-computed expected outputs for that cycle. The monitor
// samples the DUT on each falling edge and pops and compares every entry
// queued for the current cycle.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        fetch_err;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .fetch_err       (fetch_err)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [32:0] bus;
    logic [31:0] addr;
    logic        en;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_cmp;
  int   n_bad;

  // Expected flag values after a misaligned redirect, depending on the build.
`ifdef IF_ALIGN_CHECK_EN
  localparam logic MIS_EN  = 1'b0;
  localparam logic MIS_ERR = 1'b1;
`else
  localparam logic MIS_EN  = 1'b1;
  localparam logic MIS_ERR = 1'b0;
`endif

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle index used to tag expectations.
  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Global time bound.
  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input string fld, input logic [32:0] act, input logic [32:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  // Monitor: pop and compare every expectation queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk(e.name, "bus",  if_to_id_bus,            e.bus);
        chk(e.name, "addr", {1'b0, inst_sram_addr},  {1'b0, e.addr});
        chk(e.name, "en",   {32'h0, inst_sram_en},   {32'h0, e.en});
        chk(e.name, "err",  {32'h0, fetch_err},      {32'h0, e.err});
        chk(e.name, "wr",   {inst_sram_wen, inst_sram_wdata[28:0]} | {29'h0, inst_sram_wdata[31:29], 1'b0}, 33'h0);
      end
    end
  end

  task automatic expect_now(input string nm, input logic [32:0] eb, input logic [31:0] ea,
                            input logic een, input logic eerr);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.bus  = eb;
    e.addr = ea;
    e.en   = een;
    e.err  = eerr;
    exp_q.push_back(e);
  endtask

  // Apply one vector, queue its expectation, advance to just after the next edge.
  task automatic step(input logic s, input logic be, input logic [31:0] ba, input string nm,
                      input logic [32:0] eb, input logic [31:0] ea, input logic een, input logic eerr);
    stall  = {5'b00000, s};
    br_bus = {be, ba};
    expect_now(nm, eb, ea, een, eerr);
    @(posedge clk);
    #1;
  endtask

  localparam logic [32:0] RST_BUS = {1'b0, 32'hBFBF_FFFC};

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst    = 1'b1;
    stall  = 6'b000000;
    br_bus = 33'h0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 32'h0, "rst_a", RST_BUS, 32'hBFC0_0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, "rst_b", RST_BUS, 32'hBFC0_0000, 1'b0, 1'b0);
    rst = 1'b0;
    // Boot sequence.
    step(1'b0, 1'b0, 32'h0, "boot0", RST_BUS,                   32'hBFC0_0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, "boot1", {1'b1, 32'hBFC0_0000},    32'hBFC0_0004, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, "boot2", {1'b1, 32'hBFC0_0004},    32'hBFC0_0008, 1'b1, 1'b0);
    // Unstalled redirect, one-edge latency.
    step(1'b0, 1'b1, 32'hBFC0_0100, "br",   {1'b1, 32'hBFC0_0008}, 32'hBFC0_0100, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "br+1", {1'b1, 32'hBFC0_0100}, 32'hBFC0_0104, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "br+2", {1'b1, 32'hBFC0_0104}, 32'hBFC0_0108, 1'b1, 1'b0);
    // Redirect during a 3-cycle stall.
    step(1'b1, 1'b1, 32'hBFC0_0200, "stl1", {1'b1, 32'hBFC0_0108}, 32'hBFC0_0200, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0,         "stl2", {1'b1, 32'hBFC0_0108}, 32'hBFC0_0200, 1'b1, 1'b0);
    step(1'b1, 1'b0, 32'h0,         "stl3", {1'b1, 32'hBFC0_0108}, 32'hBFC0_0200, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "free1", {1'b1, 32'hBFC0_0108}, 32'hBFC0_0200, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "free2", {1'b1, 32'hBFC0_0200}, 32'hBFC0_0204, 1'b1, 1'b0);
    // Pending redirect wins over a fresh redirect on the draining edge.
    step(1'b1, 1'b1, 32'hBFC0_0300, "pend",  {1'b1, 32'hBFC0_0204}, 32'hBFC0_0300, 1'b1, 1'b0);
    step(1'b0, 1'b1, 32'hBFC0_0400, "drop",  {1'b1, 32'hBFC0_0204}, 32'hBFC0_0300, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "drop+1", {1'b1, 32'hBFC0_0300}, 32'hBFC0_0304, 1'b1, 1'b0);
    // Latest redirect wins while stalled.
    step(1'b1, 1'b1, 32'h0000_1000, "late1", {1'b1, 32'hBFC0_0304}, 32'h0000_1000, 1'b1, 1'b0);
    step(1'b1, 1'b1, 32'h0000_2000, "late2", {1'b1, 32'hBFC0_0304}, 32'h0000_1000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "late3", {1'b1, 32'hBFC0_0304}, 32'h0000_2000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "late4", {1'b1, 32'h0000_2000}, 32'h0000_2004, 1'b1, 1'b0);
    // PC wrap-around.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, "wrap0", {1'b1, 32'h0000_2004}, 32'hFFFF_FFFC, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "wrap1", {1'b1, 32'hFFFF_FFFC}, 32'h0000_0000, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "wrap2", {1'b1, 32'h0000_0000}, 32'h0000_0004, 1'b1, 1'b0);
    // Async reset mid-cycle with a pending redirect.
    step(1'b1, 1'b1, 32'h0000_5000, "apend", {1'b1, 32'h0000_0004}, 32'h0000_5000, 1'b1, 1'b0);
    stall  = 6'b000001;
    br_bus = 33'h0;
    #2;
    rst = 1'b1;
    expect_now("arst", RST_BUS, 32'hBFC0_0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 32'h0, "arst_h", RST_BUS, 32'hBFC0_0000, 1'b0, 1'b0);
    rst = 1'b0;
    step(1'b0, 1'b0, 32'h0, "arst_r", RST_BUS,                32'hBFC0_0000, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, "arst_1", {1'b1, 32'hBFC0_0000}, 32'hBFC0_0004, 1'b1, 1'b0);
    // Misaligned redirect.
    step(1'b0, 1'b1, 32'hBFC0_0102, "mis0", {1'b1, 32'hBFC0_0004}, 32'hBFC0_0102, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0,         "mis1", {1'b1, 32'hBFC0_0102}, 32'hBFC0_0106, MIS_EN, MIS_ERR);
    step(1'b0, 1'b0, 32'h0,         "mis2", {1'b1, 32'hBFC0_0106}, 32'hBFC0_010A, MIS_EN, MIS_ERR);
    rst = 1'b1;
    step(1'b0, 1'b0, 32'h0, "mis_rst", RST_BUS, 32'hBFC0_0000, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    while (exp_q.size() > 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL %s.unchecked: got none expected compare", exp_q[0].name);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 clk  input  1  Sole clock; all state updates on rising edge.
REQ-002 rst  input  1  Asynchronous, active-high reset.
REQ-003 stall  input  `StallBus  Pipeline stall vector; bit 0 (`Stop/`NoStop) freezes this stage.
REQ-004 br_bus  input  `BR_WD  {br_e, br_addr[31:0]} redirect from decode stage; br_e is a single-cycle pulse.
REQ-005 if_to_id_bus  output  `IF_TO_ID_WD  {ce, pc[31:0]}; the registered fetch state consumed by decode.
REQ-006 inst_sram_en  output  1  Instruction SRAM read enable.
REQ-007 inst_sram_wen  output  4  Instruction SRAM byte write enables; constant 4'b0.
REQ-008 inst_sram_addr  output  32  Address of the next fetch (next_pc).
REQ-009 inst_sram_wdata  output  32  Constant 32'b0.
REQ-010 fetch_err  output  1  Sticky misaligned-fetch flag (see Configuration).

Function
REQ-011 State: pc_r[31:0], ce_r, pend_v, pend_addr[31:0], err_r.
REQ-012 next_pc priority: pend_v ? pend_addr : br_e ? br_addr : pc_r + 32'h4; 32-bit add, wrap 0xFFFF_FFFC -> 0x0000_0000.
REQ-013 If stall[0]==`NoStop: pc_r <= next_pc, ce_r <= 1, pend_v <= 0 on the same edge.
REQ-014 If stall[0]==`Stop: pc_r and ce_r hold; inst_sram_addr continues to present next_pc.
REQ-015 br_e==1 while stall[0]==`Stop: pend_v <= 1, pend_addr <= br_addr; redirect applied at first non-stalled edge.
REQ-016 br_e==1 while pend_v==1 and stalled: pend_addr overwritten by newest br_addr (latest redirect wins).
REQ-017 br_e==1 while pend_v==1 and not stalled: pend_addr takes priority per REQ-012; the new br_addr is discarded.
REQ-018 inst_sram_en = ce_r & ~err_r, where ce_r is the value after the first post-reset edge (i.e. en deasserted during reset and for the first cycle out of reset).
REQ-019 if_to_id_bus = {ce_r, pc_r}; latency br_e -> pc_r == br_addr is one edge when not stalled.
REQ-020 inst_sram_addr = next_pc combinationally, so synchronous SRAM data arrives one cycle later, aligned with pc_r.

Reset
REQ-021 On rst assertion, immediately and independent of clk: pc_r = 32'hBFBF_FFFC, ce_r = 0, pend_v = 0, pend_addr = 0, err_r = 0.
REQ-022 Outputs during reset: if_to_id_bus = {1'b0, 32'hBFBF_FFFC}, inst_sram_en = 0, inst_sram_addr = 32'hBFC0_0000, fetch_err = 0.
REQ-023 Reset asserted mid-stall or with pend_v set discards the pending redirect; first fetch after release is 32'hBFC0_0000.

Configuration
REQ-024 Macro IF_ALIGN_CHECK_EN.
REQ-025 Defined: if next_pc[1:0] != 0 at an updating edge, err_r <= 1 (sticky until reset), pc_r still loads, inst_sram_en forced 0.
REQ-026 Not defined: err_r and fetch_err constant 0; misaligned next_pc forwarded unchanged to inst_sram_addr.

Verification
REQ-027 Release rst, no stall -> edge 1: pc=BFC0_0000, ce=1; edge 2: pc=BFC0_0004; inst_sram_addr leads pc by 4.
REQ-028 At pc=BFC0_0008 pulse br_e, br_addr=BFC0_0100 -> next edge pc=BFC0_0100, then BFC0_0104.
REQ-029 stall[0]=Stop for 3 cycles, br_e pulse (BFC0_0200) in cycle 1 -> pc holds for 3 cycles, pend_v=1, then pc=BFC0_0200 on first free edge, pend_v=0.
REQ-030 Stalled, br_e with 0x1000 then br_e with 0x2000 -> after release pc=0x2000.
REQ-031 With IF_ALIGN_CHECK_EN, br_addr=BFC0_0102 -> pc=BFC0_0102, fetch_err=1, inst_sram_en=0 until rst; without macro fetch_err stays 0, en stays 1.
REQ-032 Assert rst asynchronously mid-cycle with pend_v=1 -> outputs take REQ-022 values before next clk edge; first fetch after release BFC0_0000.
